// File: rtl/rx_iq_frame_scheduler.sv
// RX IQ frame scheduler: queues RX1/RX2 IQ frames from the decimators and serves one frame
// per bus read request with a fixed two-cycle latency. Also reports level, overrun and underrun.
module rx_iq_frame_scheduler #(
    parameter int unsigned IQ_WIDTH = 24,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [IQ_WIDTH-1:0] rx1_i,
    input  logic [IQ_WIDTH-1:0] rx1_q,
    input  logic                rx1_valid,
    input  logic [IQ_WIDTH-1:0] rx2_i,
    input  logic [IQ_WIDTH-1:0] rx2_q,
    input  logic                rx2_valid,
    input  logic                rx2_enable,
    input  logic                rd_req,
    input  logic                overrun_clear,
    output logic [IQ_WIDTH-1:0] out_rx1_i,
    output logic [IQ_WIDTH-1:0] out_rx1_q,
    output logic [IQ_WIDTH-1:0] out_rx2_i,
    output logic [IQ_WIDTH-1:0] out_rx2_q,
    output logic                rd_ack,
    output logic                in_empty,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                iq_overrun,
    output logic [7:0]          underrun_cnt
);

    localparam int unsigned Depth  = 2 ** FIFO_AW;
    localparam int unsigned FrameW = 4 * IQ_WIDTH;
    localparam logic [FIFO_AW:0]   LvlFull = Depth[FIFO_AW:0];
    localparam logic [FIFO_AW:0]   LvlOne  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PtrOne  = FIFO_AW'(1);
    localparam logic [7:0]         UcntMax = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StLoad
    } state_e;

    state_e                state_q, state_d;
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]      level_q, level_d;
    logic [2*IQ_WIDTH-1:0] hold_q, hold_d;
    logic [FrameW-1:0]     out_q, out_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            ucnt_q, ucnt_d;
    // Remembers whether the read in flight actually popped a frame
    logic                  popped_q, popped_d;

    logic [FrameW-1:0]     mem_q [Depth];
    logic [FrameW-1:0]     rdata_q;
    logic [FrameW-1:0]     wr_frame;
    logic                  pop;
    logic                  push_ok;
    logic                  full;

    // Next-state logic for the read FSM, FIFO bookkeeping and status flags
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        hold_d    = hold_q;
        out_d     = out_q;
        rd_ack_d  = 1'b0;
        overrun_d = overrun_q;
        ucnt_d    = ucnt_q;
        popped_d  = popped_q;
        pop       = 1'b0;

        // A same-cycle RX2 strobe feeds straight into the frame being written
        if (rx2_valid) begin
            hold_d = {rx2_i, rx2_q};
        end
        wr_frame = {rx1_i, rx1_q, (rx2_enable ? hold_d : {(2 * IQ_WIDTH){1'b0}})};

        case (state_q)
            StIdle: begin
                if (rd_req) begin
                    state_d  = StFetch;
                    pop      = (level_q != '0);
                    popped_d = pop;
                end
            end
            StFetch: begin
                state_d  = StLoad;
                rd_ack_d = 1'b1;
                if (popped_q) begin
                    out_d = rdata_q;
                end else if (ucnt_q != UcntMax) begin
                    ucnt_d = ucnt_q + 8'd1;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
        full    = (level_q == LvlFull);
        push_ok = rx1_valid && (!full || pop);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (push_ok && !pop) begin
            level_d = level_q + LvlOne;
        end else if (!push_ok && pop) begin
            level_d = level_q - LvlOne;
        end

        if (overrun_clear) begin
            overrun_d = 1'b0;
        end
        if (rx1_valid && !push_ok) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            hold_q    <= '0;
            out_q     <= '0;
            rd_ack_q  <= 1'b0;
            overrun_q <= 1'b0;
            ucnt_q    <= '0;
            popped_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
            rd_ack_q  <= rd_ack_d;
            overrun_q <= overrun_d;
            ucnt_q    <= ucnt_d;
            popped_q  <= popped_d;
        end
    end

    // Frame RAM with registered read; a read of the slot being overwritten returns old data
    always_ff @(posedge clk_in) begin
        if (push_ok && !reset_in) begin
            mem_q[wr_ptr_q] <= wr_frame;
        end
        if (pop) begin
            rdata_q <= mem_q[rd_ptr_q];
        end
    end

    assign out_rx1_i    = out_q[4*IQ_WIDTH-1:3*IQ_WIDTH];
    assign out_rx1_q    = out_q[3*IQ_WIDTH-1:2*IQ_WIDTH];
    assign out_rx2_i    = out_q[2*IQ_WIDTH-1:IQ_WIDTH];
    assign out_rx2_q    = out_q[IQ_WIDTH-1:0];
    assign rd_ack       = rd_ack_q;
    assign in_empty     = (level_q == '0);
    assign fifo_level   = level_q;
    assign iq_overrun   = overrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_rx_iq_frame_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_rx_iq_frame_scheduler;

    localparam int W  = 24;
    localparam int AW = 3;
    localparam int D  = 8;

    typedef logic [4*W-1:0] frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_in = 1'b1;
    logic [W-1:0]  rx1_i = '0, rx1_q = '0, rx2_i = '0, rx2_q = '0;
    logic          rx1_valid = 1'b0, rx2_valid = 1'b0, rx2_enable = 1'b0;
    logic          rd_req = 1'b0, overrun_clear = 1'b0;
    logic [W-1:0]  out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q;
    logic          rd_ack, in_empty, iq_overrun;
    logic [AW:0]   fifo_level;
    logic [7:0]    underrun_cnt;

    rx_iq_frame_scheduler #(.IQ_WIDTH(W), .FIFO_AW(AW)) dut (
        .clk_in        (clk),
        .reset_in      (reset_in),
        .rx1_i         (rx1_i),
        .rx1_q         (rx1_q),
        .rx1_valid     (rx1_valid),
        .rx2_i         (rx2_i),
        .rx2_q         (rx2_q),
        .rx2_valid     (rx2_valid),
        .rx2_enable    (rx2_enable),
        .rd_req        (rd_req),
        .overrun_clear (overrun_clear),
        .out_rx1_i     (out_rx1_i),
        .out_rx1_q     (out_rx1_q),
        .out_rx2_i     (out_rx2_i),
        .out_rx2_q     (out_rx2_q),
        .rd_ack        (rd_ack),
        .in_empty      (in_empty),
        .fifo_level    (fifo_level),
        .iq_overrun    (iq_overrun),
        .underrun_cnt  (underrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of frames plus read-latency bookkeeping
    frame_t         mq[$];
    logic [2*W-1:0] m_hold = '0;
    frame_t         m_out = '0;
    frame_t         m_pend = '0;
    bit             m_pend_ok = 0;
    int             m_busy = 0;
    bit             m_ack = 0;
    bit             m_ovr = 0;
    int             m_ucnt = 0;

    function automatic frame_t dut_out();
        return {out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q};
    endfunction

    // Advance model and DUT by one clock using the currently driven inputs
    task automatic tick();
        logic [2*W-1:0] hnew;
        if (reset_in) begin
            mq.delete();
            m_hold = '0; m_out = '0; m_busy = 0; m_ack = 0; m_ovr = 0; m_ucnt = 0;
        end else begin
            hnew  = rx2_valid ? {rx2_i, rx2_q} : m_hold;
            m_ack = 0;
            if (m_busy == 2) begin
                m_ack = 1;
                if (m_pend_ok) m_out = m_pend;
                else if (m_ucnt < 255) m_ucnt++;
            end
            if (m_busy > 0) begin
                m_busy--;
            end else if (rd_req) begin
                m_busy    = 2;
                m_pend_ok = (mq.size() > 0);
                if (m_pend_ok) m_pend = mq.pop_front();
            end
            if (overrun_clear) m_ovr = 0;
            if (rx1_valid) begin
                if (mq.size() < D) mq.push_back({rx1_i, rx1_q, (rx2_enable ? hnew : '0)});
                else m_ovr = 1;
            end
            m_hold = hnew;
        end
        @(posedge clk);
        #1;
        rx1_valid = 0; rx2_valid = 0; rd_req = 0; overrun_clear = 0;
    endtask

    task automatic do_reset();
        reset_in = 1;
        tick();
        reset_in = 0;
    endtask

    task automatic push(input logic [W-1:0] i1);
        rx1_i = i1; rx1_q = W'($urandom); rx1_valid = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", rd_ack); end
        checks++; if (in_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", in_empty); end
        checks++; if (fifo_level !== 0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (dut_out() !== '0) begin errors++; $display("FAIL reset_out got %h want 0", dut_out()); end
        checks++; if (iq_overrun !== 1'b0 || underrun_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_flags got ovr=%0b ucnt=%0d want 0 0", iq_overrun, underrun_cnt);
        end
    endtask

    task automatic test_order();
        do_reset();
        rx2_enable = 1;
        for (int k = 1; k <= 3; k++) push(W'(k));
        checks++; if (fifo_level !== 3) begin errors++; $display("FAIL order_level got %0d want 3", fifo_level); end
        for (int k = 1; k <= 3; k++) begin
            rd_req = 1; tick();
            checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL order_early_ack got %0b want 0", rd_ack); end
            tick();
            checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL order_ack got %0b want 1", rd_ack); end
            checks++; if (out_rx1_i !== W'(k)) begin errors++; $display("FAIL order_data got %0d want %0d", out_rx1_i, k); end
            checks++; if (dut_out() !== m_out) begin errors++; $display("FAIL order_frame got %h want %h", dut_out(), m_out); end
            tick();
            checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL order_ack_len got %0b want 0", rd_ack); end
        end
        checks++; if (fifo_level !== 0 || in_empty !== 1'b1) begin
            errors++; $display("FAIL order_end got level=%0d empty=%0b want 0 1", fifo_level, in_empty);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int k = 1; k <= 9; k++) push(W'(k));
        checks++; if (fifo_level !== 8 || iq_overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_full got level=%0d ovr=%0b want 8 1", fifo_level, iq_overrun);
        end
        for (int k = 1; k <= 8; k++) begin
            rd_req = 1; tick(); tick();
            checks++; if (out_rx1_i !== W'(k) || rd_ack !== 1'b1) begin
                errors++; $display("FAIL ovr_read got %0d ack=%0b want %0d 1", out_rx1_i, rd_ack, k);
            end
            tick();
        end
        checks++; if (in_empty !== 1'b1) begin errors++; $display("FAIL ovr_drained got %0b want 1", in_empty); end
        overrun_clear = 1; tick();
        checks++; if (iq_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b want 0", iq_overrun); end
        for (int k = 0; k < 8; k++) push(W'(k + 20));
        checks++; if (iq_overrun !== 1'b0) begin errors++; $display("FAIL ovr_exact_full got %0b want 0", iq_overrun); end
        overrun_clear = 1; push(W'(99));
        checks++; if (iq_overrun !== 1'b1 || fifo_level !== 8) begin
            errors++; $display("FAIL ovr_set_wins got ovr=%0b level=%0d want 1 8", iq_overrun, fifo_level);
        end
    endtask

    task automatic test_underrun();
        frame_t prev;
        do_reset();
        rx2_enable = 1;
        push(W'(24'hABC123));
        rd_req = 1; tick(); tick(); tick();
        prev = dut_out();
        checks++; if (prev !== m_out) begin errors++; $display("FAIL und_setup got %h want %h", prev, m_out); end
        rd_req = 1; tick(); tick();
        checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL und_ack got %0b want 1", rd_ack); end
        checks++; if (dut_out() !== prev) begin errors++; $display("FAIL und_hold got %h want %h", dut_out(), prev); end
        checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL und_cnt1 got %0d want 1", underrun_cnt); end
        tick();
        for (int k = 0; k < 300; k++) begin
            rd_req = 1; tick(); tick(); tick();
        end
        checks++; if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL und_sat got %0d want 255", underrun_cnt); end
        checks++; if (underrun_cnt !== 8'(m_ucnt)) begin errors++; $display("FAIL und_model got %0d want %0d", underrun_cnt, m_ucnt); end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int k = 1; k <= 8; k++) push(W'(k));
        rd_req = 1; tick();
        push(W'(9));
        checks++; if (fifo_level !== 8 || iq_overrun !== 1'b0) begin
            errors++; $display("FAIL full_fetch_push got level=%0d ovr=%0b want 8 0", fifo_level, iq_overrun);
        end
        checks++; if (rd_ack !== 1'b1 || out_rx1_i !== W'(1)) begin
            errors++; $display("FAIL full_fetch_read got ack=%0b d=%0d want 1 1", rd_ack, out_rx1_i);
        end
        tick();
        // Push in the same cycle as the request while full
        rx1_i = W'(10); rx1_valid = 1; rd_req = 1; tick();
        checks++; if (fifo_level !== 8 || iq_overrun !== 1'b0) begin
            errors++; $display("FAIL full_req_push got level=%0d ovr=%0b want 8 0", fifo_level, iq_overrun);
        end
        tick(); tick();
        for (int k = 3; k <= 10; k++) begin
            rd_req = 1; tick(); tick();
            checks++; if (out_rx1_i !== W'(k)) begin errors++; $display("FAIL full_drain got %0d want %0d", out_rx1_i, k); end
            tick();
        end
    endtask

    task automatic test_rx2_gating();
        do_reset();
        rx2_enable = 1;
        rx2_i = 24'h123456; rx2_q = 24'h000777; rx2_valid = 1; tick();
        rx2_i = 24'h0; rx2_q = 24'h0;
        push(W'(1));
        rx2_enable = 0;
        push(W'(2));
        rx2_enable = 1;
        rx2_i = 24'hABCDEF; rx2_q = 24'h55AA55; rx2_valid = 1; push(W'(3));
        rx2_enable = 0;
        rd_req = 1; tick(); tick();
        checks++; if (out_rx2_i !== 24'h123456 || out_rx2_q !== 24'h000777) begin
            errors++; $display("FAIL rx2_on got %h %h want 123456 000777", out_rx2_i, out_rx2_q);
        end
        tick();
        rd_req = 1; tick(); tick();
        checks++; if (out_rx2_i !== 24'h0 || out_rx1_i !== W'(2)) begin
            errors++; $display("FAIL rx2_off got %h d=%0d want 0 2", out_rx2_i, out_rx1_i);
        end
        tick();
        rd_req = 1; tick(); tick();
        checks++; if (out_rx2_i !== 24'hABCDEF || out_rx2_q !== 24'h55AA55) begin
            errors++; $display("FAIL rx2_same_cycle got %h %h want abcdef 55aa55", out_rx2_i, out_rx2_q);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(W'(5)); push(W'(6));
        rd_req = 1; tick();
        reset_in = 1; tick(); reset_in = 0;
        checks++; if (rd_ack !== 1'b0 || dut_out() !== '0) begin
            errors++; $display("FAIL rmid_out got ack=%0b out=%h want 0 0", rd_ack, dut_out());
        end
        checks++; if (in_empty !== 1'b1 || fifo_level !== 0) begin
            errors++; $display("FAIL rmid_empty got empty=%0b level=%0d want 1 0", in_empty, fifo_level);
        end
        tick();
        checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL rmid_late_ack got %0b want 0", rd_ack); end
        push(W'(7));
        rd_req = 1; tick(); tick();
        checks++; if (rd_ack !== 1'b1 || out_rx1_i !== W'(7)) begin
            errors++; $display("FAIL rmid_after got ack=%0b d=%0d want 1 7", rd_ack, out_rx1_i);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rx1_i = W'($urandom); rx1_q = W'($urandom);
            rx2_i = W'($urandom); rx2_q = W'($urandom);
            rx1_valid     = ($urandom_range(0, 2) == 0);
            rx2_valid     = ($urandom_range(0, 3) == 0);
            rd_req        = ($urandom_range(0, 1) == 0);
            overrun_clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) rx2_enable = ~rx2_enable;
            reset_in = ($urandom_range(0, 499) == 0);
            tick();
            reset_in = 0;
            checks++; if (rd_ack !== m_ack) begin errors++; $display("FAIL rnd_ack c=%0d got %0b want %0b", c, rd_ack, m_ack); end
            checks++; if (dut_out() !== m_out) begin errors++; $display("FAIL rnd_out c=%0d got %h want %h", c, dut_out(), m_out); end
            checks++; if (fifo_level !== mq.size() || in_empty !== (mq.size() == 0)) begin
                errors++; $display("FAIL rnd_level c=%0d got %0d/%0b want %0d", c, fifo_level, in_empty, mq.size());
            end
            checks++; if (iq_overrun !== m_ovr || underrun_cnt !== 8'(m_ucnt)) begin
                errors++; $display("FAIL rnd_flags c=%0d got %0b/%0d want %0b/%0d", c, iq_overrun, underrun_cnt, m_ovr, m_ucnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_overrun();
        test_underrun();
        test_full_simul();
        test_rx2_gating();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
